// File: rtl/adc_seq_pkg.sv
// Shared types and default sizing for the ADC sequencer.
// One flash ADC time-shared across several analog channels.
package adc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_e;

  localparam int N_CH_DEF  = 4;
  localparam int NBITS_DEF = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requesting channel at or after rr_ptr.
// Purely combinational; wraps from N_CH-1 back to 0.
module rr_arbiter #(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0]         req,
  input  logic [$clog2(N_CH)-1:0] rr_ptr,
  output logic [$clog2(N_CH)-1:0] sel,
  output logic                    any
);

  localparam int CW = $clog2(N_CH);

  logic [CW-1:0] idx;

  // Scan from farthest to nearest so the nearest hit wins.
  always_comb begin
    sel = '0;
    any = 1'b0;
    idx = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx = CW'((int'(rr_ptr) + k) % N_CH);
      if (req[idx]) begin
        sel = idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_seq_ctrl.sv
// Sequencer sharing one flash ADC across N_CH analog inputs.
// Round-robin grant, settle window, then a valid/ready result.
module adc_seq_ctrl
  import adc_seq_pkg::*;
#(
  parameter int N_CH       = N_CH_DEF,
  parameter int NBITS      = NBITS_DEF,
  parameter int SETTLE_CYC = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  real                     ch_vin [N_CH],
  input  logic [N_CH-1:0]         req,
  output logic [N_CH-1:0]         gnt,
  output real                     adc_vin,
  input  logic [NBITS-1:0]        adc_q,
  output logic [NBITS-1:0]        dout,
  output logic [$clog2(N_CH)-1:0] dout_ch,
  output logic                    dout_ovr,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    busy
);

  localparam int CW = $clog2(N_CH);

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic [CW-1:0]     sel_q;
  logic [CW-1:0]     rr_ptr_q;
  logic [NBITS-1:0]  dout_q;
  logic [CW-1:0]     dout_ch_q;
  logic              dout_ovr_q;
  logic              dout_valid_q;
  logic [CW-1:0]     arb_sel;
  logic              arb_any;
  logic              vin_ovr;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .sel    (arb_sel),
    .any    (arb_any)
  );

  assign busy       = (state_q != IDLE);
  assign dout       = dout_q;
  assign dout_ch    = dout_ch_q;
  assign dout_ovr   = dout_ovr_q;
  assign dout_valid = dout_valid_q;
  assign vin_ovr    = (ch_vin[sel_q] < 0.0) || (ch_vin[sel_q] > 1.0);

  always_comb begin
    gnt     = '0;
    adc_vin = 0.0;
    if (state_q != IDLE) begin
      gnt[sel_q] = 1'b1;
      adc_vin    = ch_vin[sel_q];
    end
  end

  // SETTLE spans counts 0..SETTLE_CYC; capture on the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sel_q        <= '0;
      rr_ptr_q     <= '0;
      dout_q       <= '0;
      dout_ch_q    <= '0;
      dout_ovr_q   <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (arb_any) begin
            state_q <= SETTLE;
            sel_q   <= arb_sel;
            cnt_q   <= '0;
          end
        end
        SETTLE: begin
          if (cnt_q == 4'(SETTLE_CYC)) begin
            state_q      <= HOLD;
            dout_q       <= adc_q;
            dout_ch_q    <= sel_q;
            dout_ovr_q   <= vin_ovr;
            dout_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        HOLD: begin
          if (dout_valid_q && dout_ready) begin
            state_q      <= IDLE;
            dout_valid_q <= 1'b0;
            rr_ptr_q     <= (sel_q == CW'(N_CH - 1)) ? '0 : sel_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
